// File: rtl/pal_display_timing_if.sv
// Read-side link between the PAL raster generator and the display buffer.
// Handshake: fetch_req is a one-clock pixel request with no backpressure. The buffer
// answers every request with exactly one dout/dout_valid beat a fixed 3 clk later.
// vsync_dis resets the buffer's read addresses; odd_even selects the field being read.
interface pal_display_timing_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       vsync_dis;
  logic       odd_even;
  logic       fetch_req;

  modport master (input dout, dout_valid, output vsync_dis, odd_even, fetch_req);
  modport slave  (output dout, dout_valid, input vsync_dis, odd_even, fetch_req);
endinterface

// File: rtl/pal_display_timing.sv
// Interlaced PAL-D raster generator: fetches pixels from the display buffer and emits video
// with composite sync and blanking. Define PAL_TEST_PATTERN_EN to add a grey-bar test_mode input.
module pal_display_timing #(
  parameter int          H_TOTAL     = 864,
  parameter int          H_SYNC      = 64,
  parameter int          H_ACT_START = 132,
  parameter int          IW          = 640,
  parameter int          IH          = 512,
  parameter int          V_SYNC      = 3,
  parameter int          V_ACT_START = 23,
  parameter int          V_TOTAL     = 625,
  parameter logic [7:0]  BLANK_LVL   = 8'd16,
  parameter int          PIPE_DLY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
`ifdef PAL_TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  pal_display_timing_if.master  buf_if,
  output logic [7:0]            pix_out,
  output logic                  sync_n,
  output logic                  blank_n
);

  localparam int F0_LINES = (V_TOTAL + 1) / 2;
  localparam int F1_LINES = V_TOTAL / 2;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(F0_LINES);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_L = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_LO = HW'(H_ACT_START);
  localparam logic [HW-1:0] H_ACT_HI = HW'(H_ACT_START + IW);
  localparam logic [VW-1:0] V_LAST0  = VW'(F0_LINES - 1);
  localparam logic [VW-1:0] V_LAST1  = VW'(F1_LINES - 1);
  localparam logic [VW-1:0] V_SYNC_L = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO = VW'(V_ACT_START);
  localparam logic [VW-1:0] V_ACT_HI = VW'(V_ACT_START + IH / 2);

  logic [HW-1:0]       h_cnt;
  logic [VW-1:0]       v_cnt;
  logic                field;
  logic [VW-1:0]       v_last;
  logic                h_act;
  logic                v_act;
  logic                act_raw;
  logic                vs_raw;
  logic                sync_raw;
  logic                sync_r;
  logic [PIPE_DLY-1:0] sync_pipe;
  logic [PIPE_DLY-1:0] blank_pipe;
  logic                valid_win;
  logic                align_err;

  always_comb begin
    v_last   = field ? V_LAST1 : V_LAST0;
    h_act    = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
    v_act    = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
    act_raw  = h_act && v_act;
    vs_raw   = (v_cnt < V_SYNC_L);
    sync_raw = (h_cnt < H_SYNC_L) || vs_raw;
  end

  // Field 0 carries the extra half-frame line (313 vs 312).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      field <= 1'b0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
      field <= 1'b0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == v_last) begin
        v_cnt <= '0;
        field <= ~field;
      end else begin
        v_cnt <= v_cnt + VW'(1);
      end
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // While disabled the buffer is held in vsync so its read addresses stay at origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_if.vsync_dis <= 1'b1;
      buf_if.odd_even  <= 1'b0;
      buf_if.fetch_req <= 1'b0;
      sync_r           <= 1'b0;
    end else if (!en) begin
      buf_if.vsync_dis <= 1'b1;
      buf_if.odd_even  <= 1'b0;
      buf_if.fetch_req <= 1'b0;
      sync_r           <= 1'b0;
    end else begin
      buf_if.vsync_dis <= vs_raw;
      buf_if.odd_even  <= field;
      buf_if.fetch_req <= act_raw;
      sync_r           <= sync_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe  <= '0;
      blank_pipe <= '0;
    end else if (!en) begin
      sync_pipe  <= '0;
      blank_pipe <= '0;
    end else begin
      sync_pipe  <= {sync_pipe[PIPE_DLY-2:0], sync_r};
      blank_pipe <= {blank_pipe[PIPE_DLY-2:0], buf_if.fetch_req};
    end
  end

  assign sync_n    = ~sync_pipe[PIPE_DLY-1];
  assign blank_n   = blank_pipe[PIPE_DLY-1];
  // Stage that lines up with dout_valid; it becomes blank_n on the same edge pix_out loads.
  assign valid_win = blank_pipe[PIPE_DLY-2];

`ifdef PAL_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W = HW'(IW / 8);

  logic [2:0] bar_pipe [PIPE_DLY];
  logic [7:0] bar_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) bar_pipe[i] <= '0;
    end else begin
      bar_pipe[0] <= 3'((h_cnt - H_ACT_LO) / BAR_W);
      for (int i = 1; i < PIPE_DLY; i++) bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  always_comb begin
    bar_lvl = 8'd16 + {bar_pipe[PIPE_DLY-1], 5'd0};
    if (bar_lvl > 8'd235) bar_lvl = 8'd235;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out   <= BLANK_LVL;
      align_err <= 1'b0;
    end else begin
      pix_out <= BLANK_LVL;
      if (en && valid_win) begin
`ifdef PAL_TEST_PATTERN_EN
        if (test_mode) pix_out <= bar_lvl;
        else if (buf_if.dout_valid) pix_out <= buf_if.dout;
`else
        if (buf_if.dout_valid) pix_out <= buf_if.dout;
`endif
      end
      if (en && buf_if.dout_valid && !valid_win) align_err <= 1'b1;
    end
  end

  cover property (@(posedge clk) align_err);

endmodule
